id_stage: RTL and testbench

Instruction-decode stage of the 16-bit, 4-bit-opcode pipelined processor, sitting directly downstream of the fetch stage. It owns the IF/ID pipeline register, the 8 x 16-bit register file, instruction decode, BZ branch resolution and load-use/branch hazard stalling. It feeds a registered ID/EX bundle to the execute stage and drives `enable1`, `branch_taken` and `branch_offse` back to fetch.

---
 rtl/id_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction-decode stage of the 16-bit, 4-bit-opcode pipeline.
//
// Owns the IF/ID pipeline register, the 8 x 16-bit register file (r0 reads
// as zero), instruction decode, BZ branch resolution and hazard stalling.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   if_pc, if_instruction     instruction presented by fetch
//   wb_we, wb_addr, wb_data   register-file write-back
//   ex_mem_read, ex_reg_write, ex_rd   EX-stage hazard information
//   mem_reg_write, mem_rd              MEM-stage hazard information
//   enable1            fetch PC advance enable (0 = stall), combinational
//   branch_taken       BZ in ID is taken, combinational
//   branch_offse       imm6 of the ID instruction, combinational
//   id_*               registered ID/EX bundle
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int NUM_REGS = 8,
    parameter int DATA_WID = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          if_pc,
    input  logic [15:0]         if_instruction,
    input  logic                wb_we,
    input  logic [2:0]          wb_addr,
    input  logic [DATA_WID-1:0] wb_data,
    input  logic                ex_mem_read,
    input  logic                ex_reg_write,
    input  logic [2:0]          ex_rd,
    input  logic                mem_reg_write,
    input  logic [2:0]          mem_rd,
    output logic                enable1,
    output logic                branch_taken,
    output logic [5:0]          branch_offse,
    output logic                id_valid,
    output logic [7:0]          id_pc,
    output logic [2:0]          id_alu_op,
    output logic                id_alu_src_imm,
    output logic                id_mem_read,
    output logic                id_mem_write,
    output logic                id_reg_write,
    output logic [2:0]          id_rd,
    output logic [DATA_WID-1:0] id_rs_data,
    output logic [DATA_WID-1:0] id_rt_data,
    output logic [DATA_WID-1:0] id_imm
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SRU  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;

    typedef struct packed {
        logic                valid;
        logic [7:0]          pc;
        logic [2:0]          alu_op;
        logic                alu_src_imm;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic [2:0]          rd;
        logic [DATA_WID-1:0] rs_data;
        logic [DATA_WID-1:0] rt_data;
        logic [DATA_WID-1:0] imm;
    } id_ex_t;

    // IF/ID register
    logic                ifid_valid_q, ifid_valid_d;
    logic [7:0]          ifid_pc_q,    ifid_pc_d;
    logic [15:0]         ifid_instr_q, ifid_instr_d;

    // register file and ID/EX bundle
    logic [DATA_WID-1:0] regs_q [NUM_REGS];
    logic [DATA_WID-1:0] regs_d [NUM_REGS];
    id_ex_t              id_ex_q, id_ex_d;

    // decode signals
    logic [3:0]          op_s;
    logic [2:0]          rd_addr_s, rs_addr_s, rt_addr_s;
    logic [2:0]          alu_op_s;
    logic                src_imm_s, mem_read_s, mem_write_s, reg_write_s;
    logic                uses_rs_s, uses_rt_s, is_bz_s;
    logic [DATA_WID-1:0] rs_val_s, rt_val_s;
    logic                load_use_s, bz_haz_s, stall_s, taken_s;

    assign op_s      = ifid_instr_q[15:12];
    assign rd_addr_s = ifid_instr_q[11:9];
    assign rs_addr_s = ifid_instr_q[8:6];

    // Opcode decode; NOP, BZ and undefined opcodes leave every control bit low
    always_comb begin
        alu_op_s    = 3'd0;
        src_imm_s   = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        uses_rs_s   = 1'b0;
        uses_rt_s   = 1'b0;
        is_bz_s     = 1'b0;
        rt_addr_s   = ifid_instr_q[5:3];
        case (op_s)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                // R-type opcodes 1..8 map onto ALU codes 0..7 in order
                alu_op_s    = 3'(op_s - OP_ADD);
                reg_write_s = 1'b1;
                uses_rs_s   = 1'b1;
                uses_rt_s   = 1'b1;
            end
            OP_ADDI: begin
                src_imm_s   = 1'b1;
                reg_write_s = 1'b1;
                uses_rs_s   = 1'b1;
            end
            OP_LD: begin
                src_imm_s   = 1'b1;
                mem_read_s  = 1'b1;
                reg_write_s = 1'b1;
                uses_rs_s   = 1'b1;
            end
            OP_ST: begin
                // store data register lives in [11:9] and rides the rt path
                src_imm_s   = 1'b1;
                mem_write_s = 1'b1;
                uses_rs_s   = 1'b1;
                uses_rt_s   = 1'b1;
                rt_addr_s   = rd_addr_s;
            end
            OP_BZ: begin
                uses_rs_s   = 1'b1;
                is_bz_s     = 1'b1;
            end
            default: begin
                alu_op_s    = 3'd0;
            end
        endcase
    end

    // Register-file read ports: r0 is zero, a same-cycle write-back bypasses
    always_comb begin
        rs_val_s = '0;
        rt_val_s = '0;
        if (rs_addr_s == 3'd0) begin
            rs_val_s = '0;
        end else if (wb_we && (wb_addr == rs_addr_s)) begin
            rs_val_s = wb_data;
        end else begin
            rs_val_s = regs_q[rs_addr_s];
        end
        if (rt_addr_s == 3'd0) begin
            rt_val_s = '0;
        end else if (wb_we && (wb_addr == rt_addr_s)) begin
            rt_val_s = wb_data;
        end else begin
            rt_val_s = regs_q[rt_addr_s];
        end
    end

    // A BZ must see its rs fully written back, so any in-flight writer stalls it
    assign load_use_s = ifid_valid_q && ex_mem_read && (ex_rd != 3'd0) &&
                        ((uses_rs_s && (ex_rd == rs_addr_s)) ||
                         (uses_rt_s && (ex_rd == rt_addr_s)));
    assign bz_haz_s   = ifid_valid_q && is_bz_s && (rs_addr_s != 3'd0) &&
                        ((ex_reg_write  && (ex_rd  == rs_addr_s)) ||
                         (mem_reg_write && (mem_rd == rs_addr_s)));
    assign stall_s    = load_use_s || bz_haz_s;
    assign taken_s    = ifid_valid_q && is_bz_s && (rs_val_s == '0) && !stall_s;

    assign enable1      = !stall_s;
    assign branch_taken = taken_s;
    assign branch_offse = ifid_instr_q[5:0];

    // IF/ID next state: bubble behind a taken branch, hold while stalled
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (taken_s) begin
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 8'd0;
            ifid_instr_d = 16'h0000;
        end else if (!stall_s) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = if_pc;
            ifid_instr_d = if_instruction;
        end else begin
            ifid_valid_d = ifid_valid_q;
        end
    end

    // ID/EX next state: decoded instruction, or an all-zero bubble on stall
    always_comb begin
        id_ex_d = '0;
        if (ifid_valid_q && !stall_s) begin
            id_ex_d.valid       = 1'b1;
            id_ex_d.pc          = ifid_pc_q;
            id_ex_d.alu_op      = alu_op_s;
            id_ex_d.alu_src_imm = src_imm_s;
            id_ex_d.mem_read    = mem_read_s;
            id_ex_d.mem_write   = mem_write_s;
            id_ex_d.reg_write   = reg_write_s;
            id_ex_d.rd          = rd_addr_s;
            id_ex_d.rs_data     = rs_val_s;
            id_ex_d.rt_data     = rt_val_s;
            id_ex_d.imm         = {{(DATA_WID-6){ifid_instr_q[5]}}, ifid_instr_q[5:0]};
        end else begin
            id_ex_d = '0;
        end
    end

    // Register-file next state; writes to r0 are dropped
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_addr != 3'd0)) begin
            regs_d[wb_addr] = wb_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 8'd0;
            ifid_instr_q <= 16'h0000;
            id_ex_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            id_ex_q      <= id_ex_d;
            regs_q       <= regs_d;
        end
    end

    assign id_valid       = id_ex_q.valid;
    assign id_pc          = id_ex_q.pc;
    assign id_alu_op      = id_ex_q.alu_op;
    assign id_alu_src_imm = id_ex_q.alu_src_imm;
    assign id_mem_read    = id_ex_q.mem_read;
    assign id_mem_write   = id_ex_q.mem_write;
    assign id_reg_write   = id_ex_q.reg_write;
    assign id_rd          = id_ex_q.rd;
    assign id_rs_data     = id_ex_q.rs_data;
    assign id_rt_data     = id_ex_q.rt_data;
    assign id_imm         = id_ex_q.imm;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage. A behavioural model of the
// decode stage is compared against the DUT on every falling edge; directed
// vectors additionally pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  if_pc;
    logic [15:0] if_instruction;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_mem_read, ex_reg_write, mem_reg_write;
    logic [2:0]  ex_rd, mem_rd;
    logic        enable1, branch_taken;
    logic [5:0]  branch_offse;
    logic        id_valid, id_alu_src_imm, id_mem_read, id_mem_write, id_reg_write;
    logic [7:0]  id_pc;
    logic [2:0]  id_alu_op, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .enable1(enable1), .branch_taken(branch_taken), .branch_offse(branch_offse),
        .id_valid(id_valid), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_alu_src_imm(id_alu_src_imm), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk16(name, 16'(act), 16'(exp));
    endtask

    // ---------------- behavioural model ----------------
    // ALU code by opcode: R-type 1..8 -> 0..7, everything else ADD (0)
    localparam logic [2:0] ALU_TAB [16] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                                           3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [15:0] m_regs [8];
    logic        m_ready = 1'b0;
    logic        m_if_valid;
    logic [7:0]  m_if_pc;
    logic [15:0] m_if_instr;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [3:0]  e_op;
    logic [2:0]  e_rd;
    logic [15:0] e_rs, e_rt, e_imm;

    function automatic bit is_rtype(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic bit reads_rs(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd12);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [2:0] m_src2(input logic [15:0] ins);
        return (ins[15:12] == 4'd11) ? ins[11:9] : ins[5:3];
    endfunction

    function automatic bit m_stall();
        logic [3:0] op  = m_if_instr[15:12];
        logic [2:0] rs  = m_if_instr[8:6];
        logic [2:0] s2  = m_src2(m_if_instr);
        bit has2        = is_rtype(op) || (op == 4'd11);
        bit lu, bzh;
        if (!m_if_valid) return 1'b0;
        lu  = ex_mem_read && (ex_rd != 3'd0) &&
              ((reads_rs(op) && ex_rd == rs) || (has2 && ex_rd == s2));
        bzh = (op == 4'd12) && (rs != 3'd0) &&
              ((ex_reg_write && ex_rd == rs) || (mem_reg_write && mem_rd == rs));
        return lu || bzh;
    endfunction

    function automatic bit m_taken();
        return m_if_valid && (m_if_instr[15:12] == 4'd12) &&
               (m_read(m_if_instr[8:6]) == 16'd0) && !m_stall();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready    <= 1'b1;
            for (int k = 0; k < 8; k++) m_regs[k] <= 16'd0;
            m_if_valid <= 1'b0;
            m_if_pc    <= 8'd0;
            m_if_instr <= 16'd0;
            e_valid    <= 1'b0;
            e_pc       <= 8'd0;
            e_op       <= 4'd0;
            e_rd       <= 3'd0;
            e_rs       <= 16'd0;
            e_rt       <= 16'd0;
            e_imm      <= 16'd0;
        end else begin
            if (wb_we && wb_addr != 3'd0) m_regs[wb_addr] <= wb_data;
            if (m_if_valid && !m_stall()) begin
                e_valid <= 1'b1;
                e_pc    <= m_if_pc;
                e_op    <= m_if_instr[15:12];
                e_rd    <= m_if_instr[11:9];
                e_rs    <= m_read(m_if_instr[8:6]);
                e_rt    <= m_read(m_src2(m_if_instr));
                e_imm   <= 16'($signed(m_if_instr[5:0]));
            end else begin
                e_valid <= 1'b0;
                e_op    <= 4'd0;
            end
            if (m_taken()) begin
                m_if_valid <= 1'b0;
                m_if_instr <= 16'd0;
            end else if (!m_stall()) begin
                m_if_valid <= 1'b1;
                m_if_pc    <= if_pc;
                m_if_instr <= if_instruction;
            end
        end
    end

    // compare process: every falling edge once the model has seen reset
    always @(negedge clk) begin
        if (m_ready) begin
            chk1("m_enable1", enable1, !m_stall());
            chk1("m_branch_taken", branch_taken, m_taken());
            chk16("m_branch_offse", 16'(branch_offse), 16'(m_if_instr[5:0]));
            chk1("m_id_valid", id_valid, e_valid);
            chk16("m_id_alu_op", 16'(id_alu_op), 16'(e_valid ? ALU_TAB[e_op] : 3'd0));
            chk1("m_alu_src_imm", id_alu_src_imm, e_valid && e_op >= 4'd9 && e_op <= 4'd11);
            chk1("m_mem_read", id_mem_read, e_valid && e_op == 4'd10);
            chk1("m_mem_write", id_mem_write, e_valid && e_op == 4'd11);
            chk1("m_reg_write", id_reg_write, e_valid && e_op >= 4'd1 && e_op <= 4'd10);
            if (e_valid) begin
                chk16("m_id_pc", 16'(id_pc), 16'(e_pc));
                chk16("m_id_rd", 16'(id_rd), 16'(e_rd));
                chk16("m_id_imm", id_imm, e_imm);
                if (reads_rs(e_op)) chk16("m_rs_data", id_rs_data, e_rs);
                if (is_rtype(e_op) || e_op == 4'd11) chk16("m_rt_data", id_rt_data, e_rt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = 8'd0; if_instruction = 16'h1248;
        wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'd0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 3'd0;
        mem_reg_write = 1'b0; mem_rd = 3'd0;

        // reset held two cycles
        tick(); tick();
        chk1("rst_valid", id_valid, 1'b0);
        chk1("rst_reg_write", id_reg_write, 1'b0);
        chk16("rst_rs_data", id_rs_data, 16'd0);
        chk16("rst_imm", id_imm, 16'd0);
        chk1("rst_enable1", enable1, 1'b1);
        chk1("rst_taken", branch_taken, 1'b0);
        rst = 1'b0;
        tick();                                   // 0x1248 captured
        chk1("post_rst_bubble", id_valid, 1'b0);
        if_instruction = 16'h0000;
        tick();
        chk1("first_valid", id_valid, 1'b1);
        chk16("first_rd", 16'(id_rd), 16'd1);
        chk1("first_reg_write", id_reg_write, 1'b1);

        // ALU decode: r1=5, r2=7, ADD r3,r1,r2
        wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'd5; tick();
        wb_addr = 3'd2; wb_data = 16'd7; tick();
        wb_we = 1'b0; if_instruction = 16'h1650; if_pc = 8'd3; tick();
        if_instruction = 16'h0000; tick();
        chk16("add_alu_op", 16'(id_alu_op), 16'd0);
        chk16("add_rs", id_rs_data, 16'd5);
        chk16("add_rt", id_rt_data, 16'd7);
        chk16("add_rd", 16'(id_rd), 16'd3);
        chk1("add_reg_write", id_reg_write, 1'b1);

        // ADDI r5,r6,-2 with same-cycle write-back of r6
        if_instruction = 16'h9BBE; if_pc = 8'd4; tick();
        if_instruction = 16'h0000; wb_we = 1'b1; wb_addr = 3'd6; wb_data = 16'h00FF; tick();
        wb_we = 1'b0;
        chk16("addi_imm", id_imm, 16'hFFFE);
        chk16("addi_bypass", id_rs_data, 16'h00FF);
        chk1("addi_src_imm", id_alu_src_imm, 1'b1);

        // load-use stall on rt
        if_instruction = 16'h1650; if_pc = 8'd20; tick();
        if_instruction = 16'h1248; if_pc = 8'd21; ex_mem_read = 1'b1; ex_rd = 3'd2; #1;
        chk1("lu_enable1", enable1, 1'b0);
        tick();
        chk1("lu_bubble", id_valid, 1'b0);
        chk1("lu_bubble_rw", id_reg_write, 1'b0);
        ex_mem_read = 1'b0; ex_rd = 3'd0; #1;
        chk1("lu_resume", enable1, 1'b1);
        tick();
        chk1("lu_valid", id_valid, 1'b1);
        chk16("lu_held_pc", 16'(id_pc), 16'd20);
        chk16("lu_rt", id_rt_data, 16'd7);
        if_instruction = 16'h0000; tick(); tick();

        // taken branch: BZ r4 (=0), imm -3, pc 10
        if_instruction = 16'hC13D; if_pc = 8'd10; tick();
        if_instruction = 16'h1248; if_pc = 8'd11; #1;
        chk1("bz_taken", branch_taken, 1'b1);
        chk16("bz_offse", 16'(branch_offse), 16'h003D);
        tick();
        chk1("bz_bundle_valid", id_valid, 1'b1);
        chk1("bz_after_taken", branch_taken, 1'b0);
        if_instruction = 16'h0000; tick();
        chk1("bz_flush_bubble", id_valid, 1'b0);
        wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'd1; tick();
        wb_we = 1'b0; if_instruction = 16'hC13D; tick();
        if_instruction = 16'h0000; #1;
        chk1("bz_not_taken", branch_taken, 1'b0);
        chk16("bz_offse_nt", 16'(branch_offse), 16'h003D);
        tick();

        // BZ hazard against EX and MEM writers of r4 (=0)
        wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'd0; tick();
        wb_we = 1'b0; if_instruction = 16'hC13D; if_pc = 8'd10; tick();
        if_instruction = 16'h1248; if_pc = 8'd11; ex_reg_write = 1'b1; ex_rd = 3'd4; #1;
        chk1("bzh_enable1", enable1, 1'b0);
        chk1("bzh_taken", branch_taken, 1'b0);
        tick();
        chk1("bzh_bubble", id_valid, 1'b0);
        ex_reg_write = 1'b0; mem_reg_write = 1'b1; mem_rd = 3'd4; #1;
        chk1("bzh_mem_enable1", enable1, 1'b0);
        tick();
        mem_reg_write = 1'b0; #1;
        chk1("bzh_release", branch_taken, 1'b1);
        tick();
        if_instruction = 16'h0000; tick();

        // ST r2 -> [r1+4]; stall on its [11:9] source
        if_instruction = 16'hB444; if_pc = 8'd30; tick();
        if_instruction = 16'h0000; ex_mem_read = 1'b1; ex_rd = 3'd2; #1;
        chk1("st_src_stall", enable1, 1'b0);
        tick();
        ex_mem_read = 1'b0; tick();
        chk1("st_mem_write", id_mem_write, 1'b1);
        chk16("st_rt", id_rt_data, 16'd7);
        chk16("st_rs", id_rs_data, 16'd5);
        chk1("st_reg_write", id_reg_write, 1'b0);

        // LD r7,[r2-32]
        if_instruction = 16'hAEA0; tick();
        if_instruction = 16'h0000; tick();
        chk1("ld_mem_read", id_mem_read, 1'b1);
        chk16("ld_imm", id_imm, 16'hFFE0);
        chk16("ld_rs", id_rs_data, 16'd7);

        // ex_rd = r0 never stalls; r0 write is dropped
        if_instruction = 16'h1000; tick();
        if_instruction = 16'h0000; ex_mem_read = 1'b1; ex_rd = 3'd0; #1;
        chk1("ex_rd0_nostall", enable1, 1'b1);
        tick();
        ex_mem_read = 1'b0;
        if_instruction = 16'h1200; tick();
        if_instruction = 16'h0000; wb_we = 1'b1; wb_addr = 3'd0; wb_data = 16'hBEEF; tick();
        wb_we = 1'b0;
        chk16("r0_read", id_rs_data, 16'd0);

        // opcode sweep with mixed hazard/write-back traffic, model-checked
        for (int i = 0; i < 48; i++) begin
            if_instruction = {4'(i), 12'(i * 397 + 17)};
            if_pc          = 8'(100 + i);
            ex_mem_read    = (i % 3 == 0);
            ex_rd          = 3'(i);
            ex_reg_write   = (i % 4 == 1);
            mem_reg_write  = (i % 5 == 2);
            mem_rd         = 3'(i / 2);
            wb_we          = (i % 2 == 1);
            wb_addr        = 3'(i + 3);
            wb_data        = 16'(i * 4099);
            tick();
        end
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_we = 1'b0;

        // mid-operation reset discards pipeline and register contents
        if_instruction = 16'h1650; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk1("midrst_valid", id_valid, 1'b0);
        chk1("midrst_enable1", enable1, 1'b1);
        chk1("midrst_taken", branch_taken, 1'b0);
        tick();
        if_instruction = 16'h0000; tick();
        chk1("midrst_new_valid", id_valid, 1'b1);
        chk16("midrst_rs_cleared", id_rs_data, 16'd0);
        chk16("midrst_rt_cleared", id_rt_data, 16'd0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
